// File: rtl/fetch_stage_pkg.sv
// Shared widths, bubble encoding and IF/ID record for the fetch stage.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the fetch stage, its next-PC mux and the interface.
package fetch_stage_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam int DATA_W  = 32;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [DATA_W-1:0]  data_t;

    localparam instr_t NOP_INSTR = 32'h0000_0000;

    // IF/ID pipeline record; vld low marks a bubble.
    typedef struct packed {
        instr_t instruction;
        pc_t    pc_plus1;
        logic   vld;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instruction: NOP_INSTR, pc_plus1: '0, vld: 1'b0};

    // Word-addressed increment; wraps at 2^PC_W without a carry flag.
    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: hazard stall, decode redirect inputs, imem port and IF/ID outputs.
// Wires only; zero latency; stall is the sole hold mechanism (no valid/ready).
// master drives decode/imem side, slave is the fetch stage itself.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic   stall;
    logic   PCSrc;
    pc_t    adderResult;
    logic   jump;
    logic   jal;
    pc_t    jaddress;
    logic   jr;
    data_t  readData1;
    instr_t imem_rdata;
    pc_t    imem_addr;
    instr_t instruction;
    pc_t    PCPlus1;
    logic   if_valid;
    logic   redirect;

    modport master (
        output stall, PCSrc, adderResult, jump, jal, jaddress, jr, readData1, imem_rdata,
        input  imem_addr, instruction, PCPlus1, if_valid, redirect
    );

    modport slave (
        input  stall, PCSrc, adderResult, jump, jal, jaddress, jr, readData1, imem_rdata,
        output imem_addr, instruction, PCPlus1, if_valid, redirect
    );

endinterface

// File: rtl/fetch_stage_next_pc_mux.sv
// Priority select of the next PC: jr, then branch, then j/jal, else sequential.
// Purely combinational; redirect is suppressed while stalled since decode operands are stale.
// No backpressure of its own; the caller applies stall to the registers.
module fetch_stage_next_pc_mux
    import fetch_stage_pkg::*;
(
    input  logic stall,
    input  logic jr,
    input  logic PCSrc,
    input  logic jump,
    input  logic jal,
    input  pc_t  jr_target,
    input  pc_t  adderResult,
    input  pc_t  jaddress,
    input  pc_t  pc_plus1,
    output pc_t  target,
    output logic redirect
);

    always_comb begin
        target = pc_plus1;
        if (jr) begin
            target = jr_target;
        end else if (PCSrc) begin
            target = adderResult;
        end else if (jump || jal) begin
            target = jaddress;
        end
    end

    assign redirect = (jr | PCSrc | jump | jal) & ~stall;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register; imem_addr is the PC, imem read is combinational.
// Latency PC -> IF/ID is one cycle; a taken redirect costs exactly one bubble.
// stall holds PC and IF/ID and masks redirects; rst overrides everything.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fetch_stage_if.slave fe
);

    pc_t   pc;
    pc_t   pc_plus1;
    pc_t   target;
    logic  redirect;
    ifid_t ifid;

    assign pc_plus1 = pc_inc(pc);

    // Only the low PC_W bits of the register operand form a jr target.
    logic unused_rd1_hi;
    assign unused_rd1_hi = ^fe.readData1[DATA_W-1:PC_W];

    fetch_stage_next_pc_mux u_next_pc_mux (
        .stall       (fe.stall),
        .jr          (fe.jr),
        .PCSrc       (fe.PCSrc),
        .jump        (fe.jump),
        .jal         (fe.jal),
        .jr_target   (fe.readData1[PC_W-1:0]),
        .adderResult (fe.adderResult),
        .jaddress    (fe.jaddress),
        .pc_plus1    (pc_plus1),
        .target      (target),
        .redirect    (redirect)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= '0;
            ifid <= IFID_BUBBLE;
        end else if (!fe.stall) begin
            pc <= target;
            // The sequentially fetched word is wrong-path whenever we redirect.
            if (redirect) begin
                ifid <= IFID_BUBBLE;
            end else begin
                ifid <= '{instruction: fe.imem_rdata, pc_plus1: pc_plus1, vld: 1'b1};
            end
        end
    end

    assign fe.imem_addr   = pc;
    assign fe.instruction = ifid.instruction;
    assign fe.PCPlus1     = ifid.pc_plus1;
    assign fe.if_valid    = ifid.vld;
    assign fe.redirect    = redirect;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed cases then random traffic vs a behavioural model.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if fe();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .fe  (fe)
    );

    logic [31:0] mem [1024];
    assign fe.imem_rdata = mem[fe.imem_addr];

    typedef struct {
        bit          redir;
        int          pc;
        logic [31:0] instr;
        int          pcp1;
        bit          vld;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;
    bit done  = 0;

    // Reference state: what the spec says pc and IF/ID hold after each edge.
    int          m_pc;
    logic [31:0] m_instr;
    int          m_pcp1;
    bit          m_vld;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), predict the result, queue it.
    task automatic drive(input bit r, input bit st, input bit ps, input int adr,
                         input bit jmp, input bit jl, input int ja,
                         input bit j_r, input logic [31:0] rd1);
        exp_t e;
        bit   any;
        rst            = r;
        fe.stall       = st;
        fe.PCSrc       = ps;
        fe.adderResult = 10'(adr);
        fe.jump        = jmp;
        fe.jal         = jl;
        fe.jaddress    = 10'(ja);
        fe.jr          = j_r;
        fe.readData1   = rd1;
        any     = jmp | jl | ps | j_r;
        e.redir = !st && any;
        if (r) begin
            m_pc = 0; m_instr = 32'h0; m_pcp1 = 0; m_vld = 0;
        end else if (!st) begin
            if (any) begin
                if (j_r)     m_pc = int'(rd1 & 32'h3FF);
                else if (ps) m_pc = adr % 1024;
                else         m_pc = ja % 1024;
                m_instr = 32'h0; m_pcp1 = 0; m_vld = 0;
            end else begin
                m_instr = mem[m_pc];
                m_pcp1  = (m_pc + 1) % 1024;
                m_vld   = 1;
                m_pc    = m_pcp1;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.pcp1 = m_pcp1; e.vld = m_vld;
        exp_q.push_back(e);
        #1;
        assert (rst || !fe.redirect || fe.if_valid)
            else $error("redirect taken while IF/ID holds a bubble");
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    // Monitor: the DUT presents a new pc/IF-ID every edge; compare against queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("redirect",    fe.redirect,    e.redir);
                chk("imem_addr",   fe.imem_addr,   e.pc);
                chk("instruction", fe.instruction, e.instr);
                chk("PCPlus1",     fe.PCPlus1,     e.pcp1);
                chk("if_valid",    fe.if_valid,    e.vld);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int k = 0; k < 1024; k++) mem[k] = 32'(k);
        fe.stall = 1; fe.PCSrc = 0; fe.adderResult = '0; fe.jump = 0; fe.jal = 0;
        fe.jaddress = '0; fe.jr = 0; fe.readData1 = '0;
        @(negedge clk);

        // Reset dominates stall and a pending branch.
        drive(1, 1, 1, 5, 0, 0, 0, 0, 32'h0);
        drive(1, 1, 1, 5, 0, 0, 0, 0, 32'h0);
        // Sequential fetch from 0.
        idle(4);
        // Taken branch to 40: one bubble, then mem[40].
        drive(0, 0, 1, 40, 0, 0, 0, 0, 32'h0);
        idle(2);
        // jr beats branch beats jump; upper readData1 bits ignored.
        drive(0, 0, 1, 5, 1, 0, 9, 1, 32'hFFFF_F07B);
        idle(2);
        // Stall masks a jump for three cycles, then the jump is taken.
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1, 0, 200, 0, 32'h0);
        drive(0, 0, 0, 0, 1, 0, 200, 0, 32'h0);
        idle(2);
        // jal alone redirects to 1023, then sequential fetch wraps to 0.
        drive(0, 0, 0, 0, 0, 1, 1023, 0, 32'h0);
        idle(3);

        for (int k = 0; k < 1024; k++) mem[k] = $urandom;
        for (int i = 0; i < 500; i++) begin
            bit st, ps, jmp, jl, j_r;
            st  = ($urandom_range(0, 3) == 0);
            ps  = 0; jmp = 0; jl = 0; j_r = 0;
            // Decode never redirects while it holds a bubble; stalled cycles may carry noise.
            if (st || (m_vld && $urandom_range(0, 3) == 0)) begin
                ps  = $urandom_range(0, 1) == 1;
                jmp = $urandom_range(0, 1) == 1;
                jl  = $urandom_range(0, 1) == 1;
                j_r = $urandom_range(0, 1) == 1;
            end
            drive(0, st, ps, $urandom_range(0, 1023), jmp, jl, $urandom_range(0, 1023),
                  j_r, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage 10-bit-PC core.
- Produces `instruction` and `PCPlus1` for the decode stage.
- Consumes decode's control-flow outputs (`PCSrc`, `adderResult`, `jump`, `jal`, `jaddress`, `jr`, `readData1`) to redirect the PC.
- Squashes the wrong-path instruction already fetched.

Parameters:
- PC_W, 10, PC / instruction-memory address width (word addressed).
- INSTR_W, 32, instruction width.
- NOP_INSTR, 32'h0000_0000, bubble inserted on flush and reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; hold PC and IF/ID contents.
- PCSrc  input  1  from decode; conditional branch taken.
- adderResult  input  PC_W  from decode; branch target.
- jump  input  1  from decode; j or jal.
- jal  input  1  from decode; qualifies jump (link handled downstream, target identical).
- jaddress  input  PC_W  from decode; absolute jump target.
- jr  input  1  from decode; jump register.
- readData1  input  32  from decode; jr target source (bits [PC_W-1:0]).
- imem_rdata  input  INSTR_W  asynchronous-read instruction memory data at imem_addr.
- imem_addr  output  PC_W  current PC.
- instruction  output  INSTR_W  IF/ID registered instruction.
- PCPlus1  output  PC_W  IF/ID registered PC+1 of that instruction.
- if_valid  output  1  IF/ID slot holds a real (non-bubble) instruction.
- redirect  output  1  combinational; a PC redirect is being taken this cycle (debug/perf).

Behaviour:
- State: pc register (PC_W), IF/ID register {instruction, PCPlus1, if_valid}.
- imem_addr = pc at all times. Instruction memory is combinational read, so latency from PC to IF/ID is 1 cycle.
- Reset (rst=1 at posedge): pc<=0, instruction<=NOP_INSTR, PCPlus1<=0, if_valid<=0. rst dominates stall and all redirects.
- pc_plus1 = pc + 1, modulo 2^PC_W (1023 -> 0, no flag).
- Redirect select, highest priority first:
  - jr: target = readData1[PC_W-1:0]; upper bits ignored.
  - PCSrc: target = adderResult.
  - jump or jal: target = jaddress.
  - none: pc_plus1.
- redirect = jr | PCSrc | jump | jal, gated by !stall.
- Per-cycle update, in priority order:
  1. stall=1: pc holds, IF/ID holds. Redirect inputs are ignored because decode operands are not yet valid; decode re-presents them next cycle.
  2. stall=0 and redirect: pc<=target; IF/ID <= {NOP_INSTR, 0, 0}. This flushes the sequentially fetched wrong-path instruction.
  3. stall=0, no redirect: pc<=pc_plus1; IF/ID <= {imem_rdata, pc_plus1, 1}.
- Net branch/jump penalty is exactly one bubble cycle.
- A redirect arriving while if_valid=0 (decode holding a bubble) cannot occur, because decode's NOP decodes to no control flow. Bench asserts this.
- Back-to-back redirects are legal only with an intervening bubble; no extra handling.
- No internal FSM beyond the pc/IF-ID registers; all outputs are registered except imem_addr (= pc, registered) and redirect.

Decomposition:
- Shared package: NOP_INSTR, PC_W, INSTR_W constants.
- One sub-module, next_pc_mux: purely combinational priority select of {readData1 slice, adderResult, jaddress, pc_plus1}. Outputs target and redirect.
- Registers stay in fetch_stage.

Test Plan:
- Reset: assert rst 2 cycles with stall=1 and PCSrc=1 -> pc=0, instruction=0, PCPlus1=0, if_valid=0; first cycle after release imem_addr=0.
- Sequential: memory holds word k at address k, 4 cycles no redirect -> imem_addr 0,1,2,3. IF/ID after cycle n holds instruction=n, PCPlus1=n+1, if_valid=1.
- Branch taken: PCSrc=1, adderResult=10'd40 for one cycle -> next imem_addr=40; IF/ID={0,0,0} for one cycle; then instruction=mem[40], PCPlus1=41.
- Priority: jr=1 with readData1=32'hFFFF_F07B, PCSrc=1 adderResult=5, jump=1 jaddress=9 simultaneously -> pc=10'h07B, one bubble.
- Stall beats redirect: stall=1 with jump=1 jaddress=200 for 3 cycles -> pc and IF/ID unchanged. Stall drops with jump still 1 -> pc=200 next cycle.
- Wrap: run from pc=1023 with no redirect -> PCPlus1 latched as 0, pc becomes 0, if_valid=1.
